// File: rtl/up_apb3_master_if.sv
// Bus bundle for up_apb3_master: the uP request/ack side and the APB3 master side.
// "master" is the bridge's view; "slave" is the view of whatever sits on both ends of it.
interface up_apb3_master_if #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int BUS_WIDTH     = 4
);
   localparam int DW = BUS_WIDTH * 8;

   logic                     up_rreq;
   logic [ADDRESS_WIDTH-1:0] up_raddr;
   logic                     up_rack;
   logic [DW-1:0]            up_rdata;
   logic                     up_rerr;
   logic                     up_wreq;
   logic [ADDRESS_WIDTH-1:0] up_waddr;
   logic [DW-1:0]            up_wdata;
   logic                     up_wack;
   logic                     up_werr;

   logic [ADDRESS_WIDTH-1:0] m_apb_paddr;
   logic                     m_apb_psel;
   logic                     m_apb_penable;
   logic                     m_apb_pwrite;
   logic [DW-1:0]            m_apb_pwdata;
   logic                     m_apb_pready;
   logic [DW-1:0]            m_apb_prdata;
   logic                     m_apb_pslverror;

   modport master (
      input  up_rreq, up_raddr, up_wreq, up_waddr, up_wdata,
      output up_rack, up_rdata, up_rerr, up_wack, up_werr,
      output m_apb_paddr, m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pwdata,
      input  m_apb_pready, m_apb_prdata, m_apb_pslverror
   );

   modport slave (
      output up_rreq, up_raddr, up_wreq, up_waddr, up_wdata,
      input  up_rack, up_rdata, up_rerr, up_wack, up_werr,
      input  m_apb_paddr, m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pwdata,
      output m_apb_pready, m_apb_prdata, m_apb_pslverror
   );
endinterface

// File: rtl/up_apb3_master.sv
// Bridge from a level-request/pulse-ack uP port to a single APB3 master, one transfer at a time.
// Every output is a register; dbg_state exposes the FSM state for checkers.
module up_apb3_master #(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int BUS_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst,
   up_apb3_master_if.master  bus,
   output logic [1:0]        dbg_state
);
   localparam int DW = BUS_WIDTH * 8;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   // Handshake: a request is a level held by the uP until its ack; the ack is a
   // one-cycle pulse with err/rdata valid in that same cycle. Write wins when both
   // requests are high in IDLE; the read is then served after an IDLE cycle.
   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
   logic [DW-1:0]            pwdata_q, pwdata_d;
   logic                     pwrite_q, pwrite_d;
   logic                     psel_q, psel_d;
   logic                     penable_q, penable_d;
   logic                     rack_q, rack_d;
   logic                     wack_q, wack_d;
   logic                     rerr_q, rerr_d;
   logic                     werr_q, werr_d;
   logic [DW-1:0]            rdata_q, rdata_d;
   logic [CW-1:0]            cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         rack_q    <= 1'b0;
         wack_q    <= 1'b0;
         rerr_q    <= 1'b0;
         werr_q    <= 1'b0;
         rdata_q   <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pwrite_q  <= pwrite_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         rack_q    <= rack_d;
         wack_q    <= wack_d;
         rerr_q    <= rerr_d;
         werr_q    <= werr_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pwrite_d  = pwrite_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      rack_d    = 1'b0;
      wack_d    = 1'b0;
      rerr_d    = 1'b0;
      werr_d    = 1'b0;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.up_wreq) begin
               paddr_d  = bus.up_waddr;
               pwdata_d = bus.up_wdata;
               pwrite_d = 1'b1;
               psel_d   = 1'b1;
               cnt_d    = '0;
               state_d  = SETUP;
            end else if (bus.up_rreq) begin
               paddr_d  = bus.up_raddr;
               pwrite_d = 1'b0;
               psel_d   = 1'b1;
               cnt_d    = '0;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (bus.m_apb_pready) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = DONE;
               if (pwrite_q) begin
                  wack_d = 1'b1;
                  werr_d = bus.m_apb_pslverror;
               end else begin
                  rack_d  = 1'b1;
                  rerr_d  = bus.m_apb_pslverror;
                  rdata_d = bus.m_apb_prdata;
               end
            end else if (TIMEOUT_CYCLES != 0) begin
               // Abort on the cycle that would bring the wait count to TIMEOUT_CYCLES.
               if (cnt_q == TO_LAST) begin
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
                  state_d   = DONE;
                  if (pwrite_q) begin
                     wack_d = 1'b1;
                     werr_d = 1'b1;
                  end else begin
                     rack_d  = 1'b1;
                     rerr_d  = 1'b1;
                     rdata_d = '0;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.m_apb_paddr   = paddr_q;
   assign bus.m_apb_pwdata  = pwdata_q;
   assign bus.m_apb_pwrite  = pwrite_q;
   assign bus.m_apb_psel    = psel_q;
   assign bus.m_apb_penable = penable_q;
   assign bus.up_rack       = rack_q;
   assign bus.up_wack       = wack_q;
   assign bus.up_rerr       = rerr_q;
   assign bus.up_werr       = werr_q;
   assign bus.up_rdata      = rdata_q;
   assign dbg_state         = state_q;
endmodule

// File: tb/tb_up_apb3_master.sv
// Directed bench for up_apb3_master: one default instance and one with a 4-cycle timeout.
module tb_up_apb3_master;
   logic       clk;
   logic       rst;
   logic [1:0] a_state;
   logic [1:0] b_state;
   int         n_checks;
   int         n_errors;

   up_apb3_master_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(4)) a_if ();
   up_apb3_master_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(4)) b_if ();

   up_apb3_master #(.ADDRESS_WIDTH(16), .BUS_WIDTH(4), .TIMEOUT_CYCLES(256)) dut_a (
      .clk(clk), .rst(rst), .bus(a_if), .dbg_state(a_state)
   );

   up_apb3_master #(.ADDRESS_WIDTH(16), .BUS_WIDTH(4), .TIMEOUT_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .bus(b_if), .dbg_state(b_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // driver
   task automatic drive_idle();
      a_if.up_rreq = 0; a_if.up_raddr = '0; a_if.up_wreq = 0; a_if.up_waddr = '0; a_if.up_wdata = '0;
      a_if.m_apb_pready = 0; a_if.m_apb_prdata = '0; a_if.m_apb_pslverror = 0;
      b_if.up_rreq = 0; b_if.up_raddr = '0; b_if.up_wreq = 0; b_if.up_waddr = '0; b_if.up_wdata = '0;
      b_if.m_apb_pready = 0; b_if.m_apb_prdata = '0; b_if.m_apb_pslverror = 0;
   endtask

   int  wack_at, rack_at, both_acks, acc_cycles, spurious;
   bit  got;

   initial begin
      n_checks = 0;
      n_errors = 0;
      drive_idle();
      rst = 1'b1;
      tick();
      tick();

      // reset state
      chk("rst_psel", a_if.m_apb_psel, 0);
      chk("rst_penable", a_if.m_apb_penable, 0);
      chk("rst_pwrite", a_if.m_apb_pwrite, 0);
      chk("rst_paddr", a_if.m_apb_paddr, 0);
      chk("rst_pwdata", a_if.m_apb_pwdata, 0);
      chk("rst_acks", {a_if.up_rack, a_if.up_wack, a_if.up_rerr, a_if.up_werr}, 0);
      chk("rst_rdata", a_if.up_rdata, 0);
      chk("rst_state", a_state, 0);
      rst = 1'b0;
      tick();

      // zero-wait write
      a_if.up_wreq = 1; a_if.up_waddr = 16'h000C; a_if.up_wdata = 32'hAAAADEAD; a_if.m_apb_pready = 1;
      tick();
      chk("wr_setup_sel_en", {a_if.m_apb_psel, a_if.m_apb_penable}, 2'b10);
      chk("wr_setup_paddr", a_if.m_apb_paddr, 16'h000C);
      chk("wr_setup_pwrite", a_if.m_apb_pwrite, 1);
      chk("wr_setup_pwdata", a_if.m_apb_pwdata, 32'hAAAADEAD);
      chk("wr_setup_noack", a_if.up_wack, 0);
      tick();
      chk("wr_access_sel_en", {a_if.m_apb_psel, a_if.m_apb_penable}, 2'b11);
      chk("wr_access_paddr", a_if.m_apb_paddr, 16'h000C);
      chk("wr_access_pwdata", a_if.m_apb_pwdata, 32'hAAAADEAD);
      tick();
      chk("wr_done_wack_werr", {a_if.up_wack, a_if.up_werr}, 2'b10);
      chk("wr_done_rack", a_if.up_rack, 0);
      chk("wr_done_sel_en", {a_if.m_apb_psel, a_if.m_apb_penable}, 2'b00);
      a_if.up_wreq = 0;
      tick();
      chk("wr_idle_wack", a_if.up_wack, 0);
      chk("wr_idle_pwdata_held", a_if.m_apb_pwdata, 32'hAAAADEAD);

      // read with three wait states
      a_if.up_rreq = 1; a_if.up_raddr = 16'h0008; a_if.m_apb_pready = 0; a_if.m_apb_prdata = 32'hB0BDBEEF;
      tick();
      chk("rd_setup_sel_en", {a_if.m_apb_psel, a_if.m_apb_penable}, 2'b10);
      chk("rd_setup_pwrite", a_if.m_apb_pwrite, 0);
      chk("rd_setup_paddr", a_if.m_apb_paddr, 16'h0008);
      tick();
      tick();
      tick();
      chk("rd_wait_sel_en", {a_if.m_apb_psel, a_if.m_apb_penable}, 2'b11);
      chk("rd_wait_noack", a_if.up_rack, 0);
      a_if.m_apb_pready = 1;
      tick();
      chk("rd_done_rack_rerr", {a_if.up_rack, a_if.up_rerr}, 2'b10);
      chk("rd_done_rdata", a_if.up_rdata, 32'hB0BDBEEF);
      a_if.up_rreq = 0; a_if.m_apb_prdata = 32'h12345678;
      tick();
      chk("rd_idle_rack", a_if.up_rack, 0);
      chk("rd_idle_rdata_held", a_if.up_rdata, 32'hB0BDBEEF);

      // simultaneous write and read
      a_if.up_wreq = 1; a_if.up_waddr = 16'h0010; a_if.up_wdata = 32'h11111111;
      a_if.up_rreq = 1; a_if.up_raddr = 16'h0014; a_if.m_apb_prdata = 32'h22222222;
      wack_at = 0; rack_at = 0; both_acks = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (a_if.up_wack && a_if.up_rack) both_acks++;
         if (c == 1) chk("both_first_pwrite", {a_if.m_apb_pwrite, a_if.m_apb_paddr}, {1'b1, 16'h0010});
         if (c == 5) chk("both_second_pwrite", {a_if.m_apb_pwrite, a_if.m_apb_paddr}, {1'b0, 16'h0014});
         if (a_if.up_wack) begin wack_at = c; a_if.up_wreq = 0; end
         if (a_if.up_rack) begin
            rack_at = c; a_if.up_rreq = 0;
            chk("both_rdata", a_if.up_rdata, 32'h22222222);
            break;
         end
      end
      chk("both_wack_cycle", wack_at, 3);
      chk("both_rack_cycle", rack_at, 7);
      chk("both_no_overlap", both_acks, 0);
      tick();

      // read with slave error
      a_if.up_rreq = 1; a_if.up_raddr = 16'h0020; a_if.m_apb_prdata = 32'h33; a_if.m_apb_pslverror = 1;
      tick();
      tick();
      tick();
      chk("slverr_rack_rerr", {a_if.up_rack, a_if.up_rerr}, 2'b11);
      a_if.up_rreq = 0; a_if.m_apb_pslverror = 0;
      tick();
      chk("slverr_idle_rerr", {a_if.up_rack, a_if.up_rerr}, 2'b00);

      // reset during ACCESS, then a clean read
      a_if.up_wreq = 1; a_if.up_waddr = 16'h0030; a_if.up_wdata = 32'h5A5A5A5A; a_if.m_apb_pready = 0;
      tick();
      tick();
      chk("rst_mid_in_access", {a_if.m_apb_psel, a_if.m_apb_penable}, 2'b11);
      rst = 1; a_if.up_wreq = 0;
      tick();
      chk("rst_mid_sel_en", {a_if.m_apb_psel, a_if.m_apb_penable}, 2'b00);
      chk("rst_mid_paddr_pwdata", {a_if.m_apb_paddr, a_if.m_apb_pwdata}, 0);
      chk("rst_mid_state", a_state, 0);
      rst = 0; a_if.m_apb_pready = 1;
      spurious = 0;
      for (int c = 0; c < 4; c++) begin
         if (a_if.up_wack || a_if.up_rack) spurious++;
         tick();
      end
      chk("rst_mid_no_ack", spurious, 0);
      a_if.up_rreq = 1; a_if.up_raddr = 16'h0040; a_if.m_apb_prdata = 32'h44556677;
      tick();
      tick();
      tick();
      chk("post_rst_rack", {a_if.up_rack, a_if.up_rerr}, 2'b10);
      chk("post_rst_rdata", a_if.up_rdata, 32'h44556677);
      a_if.up_rreq = 0;
      tick();

      // timeout instance: a good read first so the zeroed rdata is visible
      b_if.up_rreq = 1; b_if.up_raddr = 16'h0044; b_if.m_apb_pready = 1; b_if.m_apb_prdata = 32'hCAFEF00D;
      tick();
      tick();
      tick();
      chk("to_pre_rdata", {b_if.up_rack, b_if.up_rdata}, {1'b1, 32'hCAFEF00D});
      b_if.up_rreq = 0; b_if.m_apb_pready = 0;
      tick();
      b_if.up_rreq = 1; b_if.up_raddr = 16'h0050; b_if.m_apb_prdata = 32'hFFFFFFFF;
      acc_cycles = 0; got = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (b_if.m_apb_psel && b_if.m_apb_penable) acc_cycles++;
         if (b_if.up_rack) begin
            got = 1; b_if.up_rreq = 0;
            chk("to_ack_cycle", c, 6);
            chk("to_rerr", b_if.up_rerr, 1);
            chk("to_rdata_zero", b_if.up_rdata, 0);
            chk("to_psel_low", b_if.m_apb_psel, 0);
            break;
         end
      end
      chk("to_ack_seen", got, 1);
      chk("to_access_cycles", acc_cycles, 4);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
